// File: rtl/tcp_rx_queue_if.sv
// Descriptor type shared with tcp_decode/tcp_arbiter, plus the bundle of
// signals between tcp_rx_queue (slave) and its producer/consumer (master).
package tcp;
  typedef struct packed {
    logic [15:0] payload_addr;
    logic [15:0] payload_size;
    logic [15:0] checksum;
    logic [7:0]  flags;
    logic [15:0] peer_port;
    logic [15:0] window;
    logic [31:0] ack_num;
    logic [31:0] sequence_num;
  } packet_t;
endpackage

interface tcp_rx_queue_if #(
  parameter int MSS      = 1460,
  parameter int SLOTS    = 4,
  parameter int RD_WIDTH = 32
);
  // Descriptor handshake: a descriptor moves on any cycle where pkt_valid &&
  // pkt_ready; pkt_valid never drops without that, and pkt/pkt_slot are
  // stable while pkt_valid && !pkt_ready.
  logic                               in_valid;
  logic [7:0]                         in_data;
  logic                               hdr_done;
  logic                               hdr_err;
  logic [15:0]                        hdr_source_port;
  logic [15:0]                        hdr_window;
  logic [15:0]                        hdr_payload_size;
  logic [31:0]                        hdr_sequence_num;
  logic [31:0]                        hdr_ack_num;
  logic [7:0]                         hdr_flags;
  logic                               pkt_valid;
  logic                               pkt_ready;
  tcp::packet_t                       pkt;
  logic [$clog2(SLOTS)-1:0]           pkt_slot;
  logic                               rd_en;
  logic [$clog2(SLOTS)-1:0]           rd_slot;
  logic [$clog2(MSS*8/RD_WIDTH)-1:0]  rd_word;
  logic [RD_WIDTH-1:0]                rd_data;
  logic                               rel_valid;
  logic [$clog2(SLOTS)-1:0]           rel_slot;
  logic [$clog2(SLOTS):0]             free_slots;
  logic [15:0]                        drop_count;

  modport slave (
    input  in_valid, in_data, hdr_done, hdr_err, hdr_source_port, hdr_window,
           hdr_payload_size, hdr_sequence_num, hdr_ack_num, hdr_flags,
           pkt_ready, rd_en, rd_slot, rd_word, rel_valid, rel_slot,
    output pkt_valid, pkt, pkt_slot, rd_data, free_slots, drop_count
  );

  modport master (
    output in_valid, in_data, hdr_done, hdr_err, hdr_source_port, hdr_window,
           hdr_payload_size, hdr_sequence_num, hdr_ack_num, hdr_flags,
           pkt_ready, rd_en, rd_slot, rd_word, rel_valid, rel_slot,
    input  pkt_valid, pkt, pkt_slot, rd_data, free_slots, drop_count
  );
endinterface

// File: rtl/tcp_rx_queue.sv
// TCP receive queue: buffers segment payloads into MSS-sized slots, publishes
// validated descriptors through a small FIFO, and counts dropped segments.
module tcp_rx_queue #(
  parameter int MSS      = 1460,
  parameter int SLOTS    = 4,
  parameter int RD_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  tcp_rx_queue_if.slave     q_if,
  output logic [1:0]        dbg_state_o
);
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int FC_W   = SLOT_W + 1;
  localparam int BPW    = RD_WIDTH / 8;
  localparam int WORDS  = MSS / BPW;
  localparam int ADDR_W = $clog2(SLOTS * WORDS);
  localparam int CNT_W  = $clog2(MSS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DROP = 2'd2} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [SLOT_W-1:0]   cur_slot_q;
  logic [SLOTS-1:0]    busy_q;
  logic [15:0]         drop_q;
  logic [RD_WIDTH-1:0] rd_data_q;
  logic [RD_WIDTH-1:0] mem [SLOTS*WORDS];

  tcp::packet_t        fifo_pkt  [SLOTS];
  logic [SLOT_W-1:0]   fifo_slot [SLOTS];
  logic [SLOT_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FC_W-1:0]     fifo_cnt_q;

  logic                free_any;
  logic [SLOT_W-1:0]   low_free;
  logic [FC_W-1:0]     free_cnt;
  logic                no_slot, overflow, live, wr_en, push, pop, can_push, drop_evt;
  logic [SLOT_W-1:0]   wr_slot, push_slot;
  logic [CNT_W-1:0]    wr_off, cnt_upd;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  int                  wr_lane;
  tcp::packet_t        push_desc;

  always_comb begin
    free_any = 1'b0;
    low_free = '0;
    free_cnt = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        low_free = SLOT_W'(i);
      end
      free_cnt = free_cnt + FC_W'(!busy_q[i]);
    end
  end

  assign pop      = q_if.pkt_ready && (fifo_cnt_q != '0);
  assign can_push = (fifo_cnt_q != FC_W'(SLOTS)) || pop;

  // A byte and hdr_done in the same cycle: the byte lands first, so the
  // length check sees the updated count (cnt_upd).
  always_comb begin
    no_slot   = (state_q == IDLE) && q_if.in_valid && !free_any;
    overflow  = (state_q == FILL) && q_if.in_valid && (byte_cnt_q == CNT_W'(MSS));
    wr_en     = q_if.in_valid && (((state_q == IDLE) && free_any) ||
                                  ((state_q == FILL) && !overflow));
    wr_slot   = (state_q == IDLE) ? low_free : cur_slot_q;
    wr_off    = (state_q == IDLE) ? '0 : byte_cnt_q;
    cnt_upd   = wr_off + CNT_W'(wr_en);
    live      = ((state_q == IDLE) && !no_slot) || ((state_q == FILL) && !overflow);
    push      = q_if.hdr_done && live && !q_if.hdr_err &&
                (16'(cnt_upd) == q_if.hdr_payload_size) && can_push;
    drop_evt  = q_if.hdr_done && !push;
    push_slot = ((state_q == IDLE) && !q_if.in_valid) ? '0 : wr_slot;
    wr_addr   = ADDR_W'(int'(wr_slot) * WORDS + int'(wr_off) / BPW);
    wr_lane   = int'(wr_off) % BPW;
    rd_addr   = ADDR_W'(int'(q_if.rd_slot) * WORDS + int'(q_if.rd_word));
  end

  always_comb begin
    push_desc              = '0;
    push_desc.payload_addr = 16'(int'(push_slot) * WORDS);
    push_desc.payload_size = q_if.hdr_payload_size;
    push_desc.flags        = q_if.hdr_flags;
    push_desc.peer_port    = q_if.hdr_source_port;
    push_desc.window       = q_if.hdr_window;
    push_desc.ack_num      = q_if.hdr_ack_num;
    push_desc.sequence_num = q_if.hdr_sequence_num;
  end

  // Release is applied first so the FSM's own slot updates take priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      cur_slot_q <= '0;
      busy_q     <= '0;
      drop_q     <= '0;
    end else begin
      if (q_if.rel_valid) busy_q[q_if.rel_slot] <= 1'b0;
      if (drop_evt && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (q_if.in_valid) begin
            if (free_any) begin
              cur_slot_q <= low_free;
              if (q_if.hdr_done) begin
                busy_q[low_free] <= push;
              end else begin
                busy_q[low_free] <= 1'b1;
                byte_cnt_q       <= CNT_W'(1);
                state_q          <= FILL;
              end
            end else if (!q_if.hdr_done) begin
              state_q <= DROP;
            end
          end
        end
        FILL: begin
          if (overflow) begin
            busy_q[cur_slot_q] <= 1'b0;
            byte_cnt_q         <= '0;
            state_q            <= q_if.hdr_done ? IDLE : DROP;
          end else if (q_if.hdr_done) begin
            busy_q[cur_slot_q] <= push;
            byte_cnt_q         <= '0;
            state_q            <= IDLE;
          end else if (q_if.in_valid) begin
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
          end
        end
        DROP: begin
          if (q_if.hdr_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + SLOT_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + SLOT_W'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + FC_W'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - FC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pkt[wr_ptr_q]  <= push_desc;
      fifo_slot[wr_ptr_q] <= push_slot;
    end
    if (wr_en) mem[wr_addr][wr_lane*8 +: 8] <= q_if.in_data;
  end

  // Registered read: a same-cycle write to the same byte returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rd_data_q <= '0;
    else if (q_if.rd_en) rd_data_q <= mem[rd_addr];
  end

  assign q_if.pkt_valid  = (fifo_cnt_q != '0);
  assign q_if.pkt        = (fifo_cnt_q != '0) ? fifo_pkt[rd_ptr_q] : '0;
  assign q_if.pkt_slot   = (fifo_cnt_q != '0) ? fifo_slot[rd_ptr_q] : '0;
  assign q_if.rd_data    = rd_data_q;
  assign q_if.free_slots = free_cnt;
  assign q_if.drop_count = drop_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_tcp_rx_queue.sv
// Directed bench for tcp_rx_queue: segment-level reference model with a
// per-cycle compare process, plus literal expectations for the key scenarios.
module tb_tcp_rx_queue;
  localparam int MSS      = 1460;
  localparam int SLOTS    = 4;
  localparam int RD_WIDTH = 32;
  localparam int WORDS    = MSS * 8 / RD_WIDTH;
  localparam int DW       = 154;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  tcp_rx_queue_if #(.MSS(MSS), .SLOTS(SLOTS), .RD_WIDTH(RD_WIDTH)) bus ();

  tcp_rx_queue #(.MSS(MSS), .SLOTS(SLOTS), .RD_WIDTH(RD_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .q_if        (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]    m_mem [SLOTS][MSS];
  bit            m_busy [SLOTS];
  logic [DW-1:0] exp_q[$];
  int            m_drops;
  int            tests;
  int            fails;
  bit            chk_en;

  function automatic int m_free();
    int c = 0;
    for (int i = 0; i < SLOTS; i++) if (!m_busy[i]) c++;
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < SLOTS; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_word(input int s, input int w);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = m_mem[s][w*4 + b];
    return v;
  endfunction

  function automatic logic [DW-1:0] make_desc(input int addr, input int size,
      input logic [7:0] flags, input logic [15:0] port, input logic [15:0] win,
      input logic [31:0] ack, input logic [31:0] seq, input int slot);
    return {16'(addr), 16'(size), 16'h0000, flags, port, win, ack, seq, 2'(slot)};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < SLOTS; i++) m_busy[i] = 1'b0;
    m_drops = 0;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pkt_valid", 160'(bus.pkt_valid), 160'(exp_q.size() != 0));
      if (exp_q.size() != 0 && bus.pkt_valid)
        check("pkt_desc", 160'({bus.pkt, bus.pkt_slot}), 160'(exp_q[0]));
      check("free_slots", 160'(bus.free_slots), 160'(m_free()));
      check("drop_count", 160'(bus.drop_count), 160'(m_drops));
      // pkt_ready is stable until the next edge, so the pop is applied now.
      if (bus.pkt_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hdr(input int size, input logic [7:0] flags, input bit err,
                           input logic [31:0] seq, input int n);
    bus.hdr_done         = 1'b1;
    bus.hdr_err          = err;
    bus.hdr_payload_size = 16'(size);
    bus.hdr_flags        = flags;
    bus.hdr_sequence_num = seq;
    bus.hdr_source_port  = seq[15:0] ^ 16'hA5A5;
    bus.hdr_window       = 16'h4000 + 16'(n);
    bus.hdr_ack_num      = seq + 32'h10;
  endtask

  task automatic send_seg(input int n, input logic [7:0] base, input logic [7:0] step,
                          input int size, input logic [7:0] flags, input bit err,
                          input logic [31:0] seq, input bit coinc, input bit rdy_end);
    int  slot;
    bit  placed;
    bit  ovf;
    bit  hdr_now;
    slot   = m_lowest();
    placed = 1'b0;
    ovf    = 1'b0;
    for (int i = 0; i <= n; i++) begin
      hdr_now = (i == n) ? (!coinc || n == 0) : (coinc && i == n - 1);
      if (i == n && !hdr_now) break;
      if (i < n) begin
        bus.in_valid = 1'b1;
        bus.in_data  = base + 8'(i) * step;
      end
      if (hdr_now) begin
        drive_hdr(size, flags, err, seq, n);
        if (rdy_end) bus.pkt_ready = 1'b1;
      end
      @(posedge clk);
      if (i < n) begin
        if (i == 0 && slot >= 0) begin
          placed       = 1'b1;
          m_busy[slot] = 1'b1;
        end
        if (placed && !ovf) begin
          if (i < MSS) m_mem[slot][i] = base + 8'(i) * step;
          else begin
            ovf          = 1'b1;
            m_busy[slot] = 1'b0;
          end
        end
      end
      if (hdr_now) begin
        if (n > 0 && (!placed || ovf)) m_drops++;
        else if (!err && n == size && exp_q.size() < SLOTS)
          exp_q.push_back(make_desc((n > 0) ? slot * WORDS : 0, size, flags,
                                    seq[15:0] ^ 16'hA5A5, 16'h4000 + 16'(n),
                                    seq + 32'h10, seq, (n > 0) ? slot : 0));
        else begin
          m_drops++;
          if (n > 0) m_busy[slot] = 1'b0;
        end
      end
      #1;
      bus.in_valid = 1'b0;
      bus.hdr_done = 1'b0;
      bus.hdr_err  = 1'b0;
    end
  endtask

  task automatic release_slot(input int s);
    bus.rel_valid = 1'b1;
    bus.rel_slot  = 2'(s);
    @(posedge clk);
    m_busy[s] = 1'b0;
    #1;
    bus.rel_valid = 1'b0;
  endtask

  task automatic read_word(input int s, input int w, output logic [31:0] got);
    bus.rd_en   = 1'b1;
    bus.rd_slot = 2'(s);
    bus.rd_word = 9'(w);
    sync();
    bus.rd_en = 1'b0;
    @(negedge clk);
    got = bus.rd_data;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] got;

  initial begin
    tests = 0; fails = 0; chk_en = 1'b0;
    model_reset();
    rst = 1'b0;
    bus.in_valid = 0; bus.in_data = 0; bus.hdr_done = 0; bus.hdr_err = 0;
    bus.hdr_source_port = 0; bus.hdr_window = 0; bus.hdr_payload_size = 0;
    bus.hdr_sequence_num = 0; bus.hdr_ack_num = 0; bus.hdr_flags = 0;
    bus.pkt_ready = 0; bus.rd_en = 0; bus.rd_slot = 0; bus.rd_word = 0;
    bus.rel_valid = 0; bus.rel_slot = 0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_pkt_valid", 160'(bus.pkt_valid), 160'(0));
    check("rst_pkt", 160'(bus.pkt), 160'(0));
    check("rst_pkt_slot", 160'(bus.pkt_slot), 160'(0));
    check("rst_free", 160'(bus.free_slots), 160'(4));
    check("rst_rd_data", 160'(bus.rd_data), 160'(0));
    check("rst_drop", 160'(bus.drop_count), 160'(0));
    check("rst_state", 160'(dbg_state), 160'(0));
    sync();
    rst = 1'b1;
    sync();

    // single segment
    send_seg(5, 8'h11, 8'h11, 5, 8'h18, 1'b0, 32'h1000, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_valid", 160'(bus.pkt_valid), 160'(1));
    check("t1_size", 160'(bus.pkt.payload_size), 160'(5));
    check("t1_slot", 160'(bus.pkt_slot), 160'(0));
    check("t1_seq", 160'(bus.pkt.sequence_num), 160'(32'h1000));
    check("t1_flags", 160'(bus.pkt.flags), 160'(8'h18));
    check("t1_free", 160'(bus.free_slots), 160'(3));
    sync();
    read_word(0, 0, got);
    check("t1_rd_lit", 160'(got), 160'(32'h44332211));
    check("t1_rd_model", 160'(got), 160'(m_word(0, 0)));
    sync();
    @(negedge clk);
    check("t1_rd_hold", 160'(bus.rd_data), 160'(32'h44332211));
    sync();
    bus.pkt_ready = 1'b1;
    sync();
    bus.pkt_ready = 1'b0;
    release_slot(0);
    @(negedge clk);
    check("t1_rel_free", 160'(bus.free_slots), 160'(4));
    sync();

    // zero-payload SYN
    send_seg(0, 8'h00, 8'h00, 0, 8'h02, 1'b0, 32'h2000, 1'b0, 1'b0);
    @(negedge clk);
    check("syn_valid", 160'(bus.pkt_valid), 160'(1));
    check("syn_size", 160'(bus.pkt.payload_size), 160'(0));
    check("syn_slot", 160'(bus.pkt_slot), 160'(0));
    check("syn_free", 160'(bus.free_slots), 160'(4));
    sync();
    bus.pkt_ready = 1'b1;
    sync();

    // exhaustion
    for (int k = 0; k < 5; k++)
      send_seg(10, 8'(k * 16), 8'h01, 10, 8'h10, 1'b0, 32'h3000 + 32'(k * 256), k[0], 1'b0);
    @(negedge clk);
    check("exh_drop", 160'(bus.drop_count), 160'(1));
    check("exh_free", 160'(bus.free_slots), 160'(0));
    sync();
    bus.pkt_ready = 1'b0;
    release_slot(2);
    send_seg(10, 8'hA0, 8'h01, 10, 8'h10, 1'b0, 32'h4000, 1'b0, 1'b0);
    @(negedge clk);
    check("exh_slot2", 160'(bus.pkt_slot), 160'(2));
    check("exh_addr", 160'(bus.pkt.payload_addr), 160'(730));
    sync();
    read_word(2, 1, got);
    check("exh_rd_lit", 160'(got), 160'(32'hA7A6A5A4));
    check("exh_rd_model", 160'(got), 160'(m_word(2, 1)));
    sync();
    bus.pkt_ready = 1'b1;
    sync();
    bus.pkt_ready = 1'b0;
    for (int s = 0; s < SLOTS; s++) release_slot(s);

    // errors
    send_seg(5, 8'h01, 8'h01, 5, 8'h18, 1'b1, 32'h7000, 1'b0, 1'b0);
    send_seg(8, 8'h01, 8'h01, 9, 8'h18, 1'b0, 32'h7100, 1'b1, 1'b0);
    send_seg(1461, 8'h00, 8'h01, 1461, 8'h18, 1'b0, 32'h7200, 1'b0, 1'b0);
    @(negedge clk);
    check("err_drop", 160'(bus.drop_count), 160'(4));
    check("err_free", 160'(bus.free_slots), 160'(4));
    check("err_valid", 160'(bus.pkt_valid), 160'(0));
    sync();

    // backpressure
    send_seg(4, 8'h30, 8'h01, 4, 8'h18, 1'b0, 32'h5000, 1'b0, 1'b0);
    send_seg(4, 8'h40, 8'h01, 4, 8'h18, 1'b0, 32'h5100, 1'b1, 1'b0);
    send_seg(4, 8'h50, 8'h01, 4, 8'h18, 1'b0, 32'h5200, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_head_seq", 160'(bus.pkt.sequence_num), 160'(32'h5000));
    check("bp_head_slot", 160'(bus.pkt_slot), 160'(0));
    sync();
    send_seg(4, 8'h60, 8'h01, 4, 8'h18, 1'b0, 32'h5300, 1'b0, 1'b0);
    release_slot(0);
    send_seg(4, 8'h70, 8'h01, 4, 8'h18, 1'b0, 32'h5400, 1'b1, 1'b1);
    @(negedge clk);
    check("bp_full_drop", 160'(bus.drop_count), 160'(4));
    check("bp_new_head", 160'(bus.pkt.sequence_num), 160'(32'h5100));
    check("bp_free", 160'(bus.free_slots), 160'(0));
    sync();
    repeat (5) sync();
    bus.pkt_ready = 1'b0;
    for (int s = 0; s < SLOTS; s++) release_slot(s);

    // reset mid-FILL
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0 + 8'(i);
      @(posedge clk);
      m_busy[0] = 1'b1;
      #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("mr_free", 160'(bus.free_slots), 160'(4));
    check("mr_drop", 160'(bus.drop_count), 160'(0));
    check("mr_valid", 160'(bus.pkt_valid), 160'(0));
    check("mr_rd_data", 160'(bus.rd_data), 160'(0));
    check("mr_state", 160'(dbg_state), 160'(0));
    sync();
    rst = 1'b1;
    sync();
    send_seg(4, 8'hD0, 8'h01, 4, 8'h18, 1'b0, 32'h6000, 1'b0, 1'b0);
    @(negedge clk);
    check("mr_next_slot", 160'(bus.pkt_slot), 160'(0));
    check("mr_next_valid", 160'(bus.pkt_valid), 160'(1));
    sync();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tcp_rx_queue.md
# tcp_rx_queue

Single-clock receive queue between `tcp_decode` and `tcp_arbiter`. Captures a decoded TCP segment's payload bytes into one of `SLOTS` MSS-sized buffer slots, validates it on header completion, and publishes a `tcp::packet_t` descriptor through a valid/ready FIFO. Payload is read back word-wide by slot, and slots are explicitly released by the consumer. Malformed, oversize or unplaceable segments are dropped and counted.

## Interface
- `MSS`, 1460, payload bytes per slot; must be a multiple of `RD_WIDTH/8`
- `SLOTS`, 4, number of payload slots; also the descriptor FIFO depth; power of two, ≥2
- `RD_WIDTH`, 32, read port width in bits; 8, 16, 32 or 64
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  payload byte strobe from `tcp_decode`
- `in_data`  in  8  payload byte
- `hdr_done`  in  1  segment-end pulse; header fields below are valid this cycle
- `hdr_err`  in  1  decode error, qualified by `hdr_done`
- `hdr_source_port`, `hdr_window`, `hdr_payload_size`  in  16 each  decoded fields
- `hdr_sequence_num`, `hdr_ack_num`  in  32 each  decoded fields
- `hdr_flags`  in  8  decoded flags
- `pkt_valid`  out  1  descriptor available
- `pkt_ready`  in  1  consumer accepts descriptor
- `pkt`  out  `tcp::packet_t`  head descriptor
- `pkt_slot`  out  `$clog2(SLOTS)`  slot holding head descriptor's payload
- `rd_en`  in  1  payload read strobe
- `rd_slot`  in  `$clog2(SLOTS)`  slot to read
- `rd_word`  in  `$clog2(MSS*8/RD_WIDTH)`  word index within slot
- `rd_data`  out  `RD_WIDTH`  read word, little-endian byte order
- `rel_valid`  in  1  release strobe
- `rel_slot`  in  `$clog2(SLOTS)`  slot to free
- `free_slots`  out  `$clog2(SLOTS)+1`  number of free slots
- `drop_count`  out  16  dropped segments, saturating at 16'hFFFF

## Operation
- State machine: IDLE, FILL, DROP.
- IDLE, `in_valid`: lowest-index free slot allocated and byte written at offset 0 -> FILL. If no slot is free -> DROP.
- IDLE, `hdr_done` with no preceding byte (zero payload, e.g. SYN/ACK): commit with no slot allocated; `pkt.payload_size=0`, `pkt_slot=0`; no release is expected.
- FILL: each `in_valid` writes at `byte_cnt` and increments it. A byte arriving at `byte_cnt==MSS` frees the slot -> DROP.
- FILL, `hdr_done`: commit if `!hdr_err`, `byte_cnt==hdr_payload_size` and the FIFO is not full. Otherwise the slot is freed and `drop_count` increments. Either path -> IDLE.
- DROP: bytes are ignored. `hdr_done` increments `drop_count` -> IDLE.
- `in_valid` and `hdr_done` in the same cycle: the byte is written (or counted) first, then the end-of-segment check uses the updated count.
- Commit: push `{payload_addr = slot*MSS*8/RD_WIDTH, payload_size, checksum=0, flags, peer_port=source_port, window, ack_num, sequence_num}` plus slot. The slot is marked busy.
- Zero-payload segment with the FIFO full: dropped and counted.
- `pkt_ready` pops the FIFO head. Popping does not free the slot.
- `rel_valid` frees `rel_slot`. Releasing an already-free slot is ignored.
- A slot released in cycle N is allocatable from cycle N+1.
- Read: `rd_data` byte i = slot byte `rd_word*RD_WIDTH/8+i`, bits `[8i+7:8i]`. Bytes beyond `payload_size` are undefined.

## Timing
- Reset values:
  - State IDLE, `byte_cnt=0`
  - All slots free: `free_slots=SLOTS`
  - FIFO empty: `pkt_valid=0`, `pkt` and `pkt_slot` all zero
  - `rd_data=0`, `drop_count=0`
- Reset mid-segment abandons the segment without counting it.
- Payload write is synchronous on the `in_valid` cycle.
- Descriptor latency: `hdr_done` in cycle N -> `pkt_valid=1` in N+1 if the FIFO was empty.
- Back-to-back segments: the next segment's first byte is accepted in N+1.
- `pkt`/`pkt_slot` stay stable while `pkt_valid && !pkt_ready`. `pkt_valid` never deasserts without a pop.
- Simultaneous push and pop on a full FIFO: both occur, so the commit succeeds.
- Read latency is 1 cycle: `rd_en` in N -> `rd_data` valid in N+1. `rd_data` holds when `rd_en=0`.
- A same-cycle write and read of the same byte returns the old data.
- `free_slots` updates the cycle after allocate/release. Allocate and release in the same cycle net to zero change.

## Test plan
- Single segment: 5 bytes 0x11..0x55, `hdr_payload_size=5`, seq=0x1000, flags=0x18 -> `pkt_valid` one cycle after `hdr_done`, `payload_size=5`, slot 0; `rd_word=0` returns 0x44332211 (`RD_WIDTH=32`); after `rel_valid` with slot 0, `free_slots=4`.
- Zero-payload SYN (flags=0x02) -> descriptor with `payload_size=0`; `free_slots` stays 4.
- Exhaustion: 5 segments of 10 bytes each, no release, `pkt_ready=1` -> 4 descriptors on slots 0..3, 5th dropped, `drop_count=1`; release slot 2, then a 6th segment lands in slot 2.
- Errors: `hdr_err=1` -> `drop_count+1`, slot freed; length mismatch (8 bytes, size 9) -> dropped; 1461 bytes -> dropped, `free_slots` back to 4.
- Backpressure: `pkt_ready=0` for 3 commits -> `pkt` stable; `hdr_done` coincident with a pop on a full FIFO -> accepted, no drop.
- Reset asserted mid-FILL after 3 bytes -> all outputs at reset values, `drop_count=0`; the next segment goes to slot 0.
